// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one operand bit per clock.
// start/busy/done handshake; bcd/ovf hold their value until the next done pulse.
module bin_to_bcd_seq #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic [4*D-1:0]   bcd,
    output logic             ovf
);

    // Handshake: start is honoured only when busy=0 (IDLE); the operand is captured
    // on that edge. done is a one-cycle pulse on which bcd/ovf are freshly valid.
    localparam int CW = $clog2(W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      bin_sh_q, bin_sh_d;
    logic [4*D-1:0]    scratch_q, scratch_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4*D-1:0]    bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic [4*D-1:0]    adj;
    logic [4*D-1:0]    scratch_sh;
    logic [W-1:0]      bin_sh_sh;
    logic              shift_out;

    // Each digit corrected independently; no carry crosses a digit boundary.
    function automatic logic [4*D-1:0] add3_all(input logic [4*D-1:0] s);
        logic [4*D-1:0] r;
        r = s;
        for (int i = 0; i < D; i++) begin
            if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        adj        = add3_all(scratch_q);
        shift_out  = adj[4*D-1];
        scratch_sh = {adj[4*D-2:0], bin_sh_q[W-1]};
        bin_sh_sh  = {bin_sh_q[W-2:0], 1'b0};
    end

    always_comb begin
        state_d   = state_q;
        bin_sh_d  = bin_sh_q;
        scratch_d = scratch_q;
        ovf_acc_d = ovf_acc_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_sh_d  = bin;
                    scratch_d = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CW'(W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bin_sh_d  = bin_sh_sh;
                scratch_d = scratch_sh;
                ovf_acc_d = ovf_acc_q | shift_out;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = scratch_sh;
                    ovf_d   = ovf_acc_q | shift_out;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_sh_q  <= '0;
            scratch_q <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_sh_q  <= bin_sh_d;
            scratch_q <= scratch_d;
            ovf_acc_q <= ovf_acc_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    // busy is the FSM state itself, so it doubles as the state observation point.
    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a D=3 instance (full range) and a D=2 instance
// (overflow), checked with immediate assertions against hand-computed values.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2;
  logic [7:0]  bin1, bin2;
  logic        busy1, busy2, done1, done2, ovf1, ovf2;
  logic [11:0] bcd1;
  logic [7:0]  bcd2;

  int pass_cnt = 0;
  int total    = 0;
  int sel      = 1;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.W(8), .D(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start1), .bin(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1)
  );

  bin_to_bcd_seq #(.W(8), .D(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
  );

  logic        busy_s, done_s, ovf_s;
  logic [11:0] bcd_s;
  assign busy_s = (sel == 1) ? busy1 : busy2;
  assign done_s = (sel == 1) ? done1 : done2;
  assign ovf_s  = (sel == 1) ? ovf1  : ovf2;
  assign bcd_s  = (sel == 1) ? bcd1  : {4'h0, bcd2};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive start for exactly one edge (edge 0 of the conversion).
  task automatic launch(input logic [7:0] v);
    if (sel == 1) begin bin1 = v; start1 = 1'b1; end
    else          begin bin2 = v; start2 = 1'b1; end
    step();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Returns in the done cycle; lat counts edges after edge 0, bounded at 20.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!done_s && lat < 20) begin
      if (!busy_s) busy_ok = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic convert(input string tag, input logic [7:0] v,
                         input logic [11:0] exp_bcd, input logic exp_ovf);
    int   lat;
    logic bok;
    launch(v);
    wait_done(lat, bok);
    check({tag, "_lat"}, lat, 8);
    check({tag, "_bcd"}, bcd_s, exp_bcd);
    check({tag, "_ovf"}, ovf_s, exp_ovf);
    check({tag, "_busy"}, {busy_s, bok}, 2'b01);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done_s) n++;
      step();
    end
  endtask

  initial begin
    int          lat;
    int          n;
    logic        bok;
    logic [11:0] exp_bcd;

    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; bin1 = '0; bin2 = '0;
    step(); step();
    rst = 1'b0;
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_bcd", bcd1, 12'h000);
    check("rst_ovf", ovf1, 1'b0);
    check("rst_bcd_d2", bcd2, 8'h00);
    step();

    convert("zero", 8'd0,   12'h000, 1'b0);
    step();
    check("done_pulse", done1, 1'b0);
    convert("v255", 8'd255, 12'h255, 1'b0);
    convert("v99",  8'd99,  12'h099, 1'b0);
    convert("v100", 8'd100, 12'h100, 1'b0);
    step();

    // start while busy is ignored: start 37, pulse again at cycle 3 with 200
    launch(8'd37);
    step(); step();
    bin1 = 8'd200; start1 = 1'b1;
    step();
    start1 = 1'b0; bin1 = 8'd0;
    wait_done(lat, bok);
    check("ign_lat", lat, 5);
    check("ign_bcd", bcd1, 12'h037);
    step();
    count_dones(12, n);
    check("ign_single_done", n, 0);
    check("ign_idle", busy1, 1'b0);

    // reset mid-conversion
    launch(8'd77);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", busy1, 1'b0);
    check("mid_rst_bcd", bcd1, 12'h000);
    check("mid_rst_done", done1, 1'b0);
    count_dones(12, n);
    check("mid_rst_no_done", n, 0);
    convert("after_rst", 8'd45, 12'h045, 1'b0);

    // start accepted in the done cycle
    convert("v200", 8'd200, 12'h200, 1'b0);
    launch(8'd128);
    check("b2b_done_drop", done1, 1'b0);
    check("b2b_busy", busy1, 1'b1);
    wait_done(lat, bok);
    check("b2b_lat", lat, 8);
    check("b2b_bcd", bcd1, 12'h128);
    step();

    // two-digit instance: overflow and its clearing on the next start
    sel = 2;
    convert("d2_v255", 8'd255, 12'h055, 1'b1);
    convert("d2_v42",  8'd42,  12'h042, 1'b0);
    convert("d2_v100", 8'd100, 12'h000, 1'b1);
    convert("d2_v99",  8'd99,  12'h099, 1'b0);

    // sweep: every operand on both instances against a decimal-digit model
    for (int v = 0; v < 256; v++) begin
      sel = 1;
      exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      convert("sweep_d3", 8'(v), exp_bcd, 1'b0);
      sel = 2;
      exp_bcd = {4'h0, 4'((v / 10) % 10), 4'(v % 10)};
      convert("sweep_d2", 8'(v), exp_bcd, (v >= 100) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
